// File: rtl/if_hart_sched_if.sv
// Hart-control, redirect and fetch-request signals between the ID/EX stages and the IF hart scheduler.
// The master side drives commands and stall; the slave (scheduler) drives fetch requests and hart status.
interface if_hart_sched_if #(
    parameter int HART_NUM  = 4,
    parameter int HART_ID_W = 2,
    parameter int WORD_W    = 32
) ();
    logic                 stall;
    logic                 hkill;
    logic                 hstart;
    logic                 hidle;
    logic [HART_ID_W-1:0] set_hid;
    logic [HART_ID_W-1:0] hs_id;
    logic [WORD_W-1:0]    hs_pc;
    logic                 redir_en;
    logic [HART_ID_W-1:0] redir_hid;
    logic [WORD_W-1:0]    redir_pc;
    logic                 fetch_en;
    logic [HART_ID_W-1:0] fetch_hid;
    logic [WORD_W-1:0]    fetch_pc;
    logic [HART_NUM-1:0]  hart_active;

    modport master (
        output stall, hkill, hstart, hidle, set_hid, hs_id, hs_pc,
        output redir_en, redir_hid, redir_pc,
        input  fetch_en, fetch_hid, fetch_pc, hart_active
    );

    modport slave (
        input  stall, hkill, hstart, hidle, set_hid, hs_id, hs_pc,
        input  redir_en, redir_hid, redir_pc,
        output fetch_en, fetch_hid, fetch_pc, hart_active
    );
endinterface

// File: rtl/if_hart_sched.sv
// IF-stage hart scheduler: per-hart ACTIVE/IDLE state and PC, hart commands, EX redirects,
// and a round-robin pick of one active hart per cycle issued as a registered fetch request.
module if_hart_sched #(
    parameter int              HART_NUM  = 4,
    parameter int              HART_ID_W = 2,
    parameter int              WORD_W    = 32,
    parameter logic [WORD_W-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           reset,
    if_hart_sched_if.slave hs
);
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} hart_state_e;

    hart_state_e          state_q [HART_NUM];
    hart_state_e          state_d [HART_NUM];
    logic [WORD_W-1:0]    pc_q    [HART_NUM];
    logic [WORD_W-1:0]    pc_d    [HART_NUM];
    logic [HART_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic                 fetch_en_q, fetch_en_d;
    logic [HART_ID_W-1:0] fetch_hid_q, fetch_hid_d;
    logic [WORD_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic [HART_NUM-1:0]  hart_active_q, hart_active_d;

    logic [HART_NUM-1:0]  eligible;
    logic [HART_ID_W-1:0] sel, idx;
    logic                 found, issue;

    function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc);
        return pc + WORD_W'(4);
    endfunction

    // Harts being killed or idled this cycle must not be fetched from.
    always_comb begin
        eligible = '0;
        found    = 1'b0;
        sel      = rr_ptr_q;
        idx      = rr_ptr_q;
        for (int i = 0; i < HART_NUM; i++) begin
            eligible[i] = (state_q[i] == ACTIVE)
                        && !(hs.hkill && (hs.hs_id == HART_ID_W'(i)))
                        && !(hs.hidle && (hs.set_hid == HART_ID_W'(i)));
        end
        for (int k = 1; k <= HART_NUM; k++) begin
            idx = rr_ptr_q + HART_ID_W'(k);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        issue = found && !hs.stall;
    end

    // Later assignments win: increment < hidle < hstart < redirect < hkill.
    always_comb begin
        hart_active_d = '0;
        for (int i = 0; i < HART_NUM; i++) begin
            state_d[i] = state_q[i];
            pc_d[i]    = pc_q[i];
            if (issue && (sel == HART_ID_W'(i)))
                pc_d[i] = pc_inc(pc_q[i]);
            if (hs.hidle && (hs.set_hid == HART_ID_W'(i)))
                state_d[i] = IDLE;
            if (hs.hstart && (hs.hs_id == HART_ID_W'(i))) begin
                state_d[i] = ACTIVE;
                pc_d[i]    = hs.hs_pc;
            end
            if (hs.redir_en && (hs.redir_hid == HART_ID_W'(i)))
                pc_d[i] = hs.redir_pc;
            if (hs.hkill && (hs.hs_id == HART_ID_W'(i))) begin
                state_d[i] = IDLE;
                pc_d[i]    = '0;
            end
            hart_active_d[i] = (state_d[i] == ACTIVE);
        end
    end

    always_comb begin
        fetch_en_d  = fetch_en_q;
        fetch_hid_d = fetch_hid_q;
        fetch_pc_d  = fetch_pc_q;
        rr_ptr_d    = rr_ptr_q;
        if (!hs.stall) begin
            fetch_en_d = found;
            if (found) begin
                fetch_hid_d = sel;
                fetch_pc_d  = pc_q[sel];
                rr_ptr_d    = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < HART_NUM; i++) begin
                state_q[i] <= (i == 0) ? ACTIVE : IDLE;
                pc_q[i]    <= (i == 0) ? RESET_PC : '0;
            end
            rr_ptr_q      <= HART_ID_W'(HART_NUM - 1);
            fetch_en_q    <= 1'b0;
            fetch_hid_q   <= '0;
            fetch_pc_q    <= '0;
            hart_active_q <= HART_NUM'(1);
        end else begin
            for (int i = 0; i < HART_NUM; i++) begin
                state_q[i] <= state_d[i];
                pc_q[i]    <= pc_d[i];
            end
            rr_ptr_q      <= rr_ptr_d;
            fetch_en_q    <= fetch_en_d;
            fetch_hid_q   <= fetch_hid_d;
            fetch_pc_q    <= fetch_pc_d;
            hart_active_q <= hart_active_d;
        end
    end

    assign hs.fetch_en    = fetch_en_q;
    assign hs.fetch_hid   = fetch_hid_q;
    assign hs.fetch_pc    = fetch_pc_q;
    assign hs.hart_active = hart_active_q;
endmodule

// File: tb/tb_if_hart_sched.sv
// Directed bench for if_hart_sched: expected fetch requests are queued as each cycle is driven
// and compared against the DUT outputs half a cycle after the clock edge that produces them.
module tb_if_hart_sched;
    localparam int HART_NUM  = 4;
    localparam int HART_ID_W = 2;
    localparam int WORD_W    = 32;

    typedef struct {
        logic              en;
        logic [1:0]        hid;
        logic [31:0]       pc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors    = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    if_hart_sched_if #(.HART_NUM(HART_NUM), .HART_ID_W(HART_ID_W), .WORD_W(WORD_W)) hs_if ();

    if_hart_sched #(
        .HART_NUM (HART_NUM),
        .HART_ID_W(HART_ID_W),
        .WORD_W   (WORD_W),
        .RESET_PC (32'h0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hs   (hs_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        hs_if.hkill     = 1'b0;
        hs_if.hstart    = 1'b0;
        hs_if.hidle     = 1'b0;
        hs_if.set_hid   = '0;
        hs_if.hs_id     = '0;
        hs_if.hs_pc     = '0;
        hs_if.redir_en  = 1'b0;
        hs_if.redir_hid = '0;
        hs_if.redir_pc  = '0;
    endtask

    // Queue the fetch expected from the coming edge, clock it, then compare at the falling edge.
    task automatic cyc(input string tag, input logic en, input logic [1:0] hid, input logic [31:0] pc);
        exp_t e;
        sb_q.push_back('{en: en, hid: hid, pc: pc});
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        chk({tag, ".en"},  32'(hs_if.fetch_en),  32'(e.en));
        chk({tag, ".hid"}, 32'(hs_if.fetch_hid), 32'(e.hid));
        chk({tag, ".pc"},  hs_if.fetch_pc,       e.pc);
        clr();
    endtask

    task automatic chk_act(input string tag, input logic [3:0] exp);
        chk(tag, 32'(hs_if.hart_active), 32'(exp));
    endtask

    initial begin
        reset       = 1'b0;
        hs_if.stall = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.en",  32'(hs_if.fetch_en),  32'd0);
        chk("rst.hid", 32'(hs_if.fetch_hid), 32'd0);
        chk("rst.pc",  hs_if.fetch_pc,       32'd0);
        chk_act("rst.act", 4'b0001);

        // T1: hart 0 fetches from the reset PC upward
        reset = 1'b1;
        cyc("t1a", 1'b1, 2'd0, 32'h0);
        cyc("t1b", 1'b1, 2'd0, 32'h4);
        cyc("t1c", 1'b1, 2'd0, 32'h8);
        chk_act("t1.act", 4'b0001);

        // T2: start hart 2 and alternate
        hs_if.hstart = 1'b1; hs_if.hs_id = 2'd2; hs_if.hs_pc = 32'h100;
        cyc("t2a", 1'b1, 2'd0, 32'hC);
        cyc("t2b", 1'b1, 2'd2, 32'h100);
        cyc("t2c", 1'b1, 2'd0, 32'h10);
        cyc("t2d", 1'b1, 2'd2, 32'h104);
        cyc("t2e", 1'b1, 2'd0, 32'h14);
        chk_act("t2.act", 4'b0101);

        // T3: kill beats start on the same hart, and the killed hart is skipped that cycle
        hs_if.hkill = 1'b1; hs_if.hstart = 1'b1; hs_if.hs_id = 2'd2; hs_if.hs_pc = 32'h200;
        cyc("t3a", 1'b1, 2'd0, 32'h18);
        chk_act("t3.act", 4'b0001);
        cyc("t3b", 1'b1, 2'd0, 32'h1C);
        cyc("t3c", 1'b1, 2'd0, 32'h20);

        // T4: redirect during issue of the same hart
        hs_if.redir_en = 1'b1; hs_if.redir_hid = 2'd0; hs_if.redir_pc = 32'h40;
        cyc("t4a", 1'b1, 2'd0, 32'h24);
        cyc("t4b", 1'b1, 2'd0, 32'h40);
        cyc("t4c", 1'b1, 2'd0, 32'h44);

        // T5: stall freezes outputs; a start during stall still applies
        hs_if.stall = 1'b1;
        hs_if.hstart = 1'b1; hs_if.hs_id = 2'd1; hs_if.hs_pc = 32'h300;
        cyc("t5s1", 1'b1, 2'd0, 32'h44);
        chk_act("t5.act_stall", 4'b0011);
        cyc("t5s2", 1'b1, 2'd0, 32'h44);
        cyc("t5s3", 1'b1, 2'd0, 32'h44);
        hs_if.stall = 1'b0;
        cyc("t5a", 1'b1, 2'd1, 32'h300);
        cyc("t5b", 1'b1, 2'd0, 32'h48);
        cyc("t5c", 1'b1, 2'd1, 32'h304);
        hs_if.redir_en = 1'b1; hs_if.redir_hid = 2'd1; hs_if.redir_pc = 32'hFFFF_FFFC;
        cyc("t5d", 1'b1, 2'd0, 32'h4C);
        cyc("t5w1", 1'b1, 2'd1, 32'hFFFF_FFFC);
        cyc("t5e", 1'b1, 2'd0, 32'h50);
        cyc("t5w2", 1'b1, 2'd1, 32'h0);

        // T6: kill hart 1, idle hart 0, then restart hart 0
        hs_if.hkill = 1'b1; hs_if.hs_id = 2'd1;
        cyc("t6a", 1'b1, 2'd0, 32'h54);
        chk_act("t6.act_kill", 4'b0001);
        hs_if.hidle = 1'b1; hs_if.set_hid = 2'd0;
        cyc("t6b", 1'b0, 2'd0, 32'h54);
        chk_act("t6.act_idle", 4'b0000);
        cyc("t6c", 1'b0, 2'd0, 32'h54);
        hs_if.hstart = 1'b1; hs_if.hs_id = 2'd0; hs_if.hs_pc = 32'h20;
        cyc("t6d", 1'b0, 2'd0, 32'h54);
        chk_act("t6.act_start", 4'b0001);
        cyc("t6e", 1'b1, 2'd0, 32'h20);

        // Redirect to an idle hart must not activate it
        hs_if.redir_en = 1'b1; hs_if.redir_hid = 2'd3; hs_if.redir_pc = 32'h500;
        cyc("t7a", 1'b1, 2'd0, 32'h24);
        chk_act("t7.act", 4'b0001);
        cyc("t7b", 1'b1, 2'd0, 32'h28);

        // Reset mid-operation discards a pending start
        reset = 1'b0;
        hs_if.hstart = 1'b1; hs_if.hs_id = 2'd3; hs_if.hs_pc = 32'h700;
        cyc("t8rst", 1'b0, 2'd0, 32'h0);
        chk_act("t8.act", 4'b0001);
        reset = 1'b1;
        cyc("t8a", 1'b1, 2'd0, 32'h0);
        cyc("t8b", 1'b1, 2'd0, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
